// File: rtl/vga_rect_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_rect_fill_ctrl
// Purpose  : Rectangle-fill sequencer driving the framebuffer write port in
//            raster order. Optional corner clamp: VGA_RECT_FILL_CLIP_EN.
// Revision : 1.0  initial release
// ============================================================================
module vga_rect_fill_ctrl #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 1,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    input  logic [COLOR_W-1:0] color_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [COORD_W-1:0] wr_addr_x_o,
    output logic [COORD_W-1:0] wr_addr_y_o,
    output logic [COLOR_W-1:0] wr_color_o,
    output logic               wr_we_o,
    input  logic               wr_ready_i
);

`ifdef VGA_RECT_FILL_CLIP_EN
    localparam bit c_clip_en = 1'b1;
`else
    localparam bit c_clip_en = 1'b0;
`endif

    // With clipping off the limit is all-ones, which makes the clamp a no-op.
    localparam logic [COORD_W-1:0] c_x_lim = c_clip_en ? COORD_W'(H_RES - 1) : {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] c_y_lim = c_clip_en ? COORD_W'(V_RES - 1) : {COORD_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 we_q, we_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]   xmin_q, xmin_d;
    logic [COORD_W-1:0]   xmax_q, xmax_d;
    logic [COORD_W-1:0]   ymax_q, ymax_d;
    logic [COLOR_W-1:0]   color_q, color_d;

    logic [COORD_W-1:0]   w_x0c, w_x1c, w_y0c, w_y1c;
    logic                 w_accept;

    assign w_x0c    = (x0_i > c_x_lim) ? c_x_lim : x0_i;
    assign w_x1c    = (x1_i > c_x_lim) ? c_x_lim : x1_i;
    assign w_y0c    = (y0_i > c_y_lim) ? c_y_lim : y0_i;
    assign w_y1c    = (y1_i > c_y_lim) ? c_y_lim : y1_i;
    assign w_accept = we_q & wr_ready_i;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = we_q;
        x_d     = x_q;
        y_d     = y_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        color_d = color_q;

        case (state_q)
            S_IDLE: begin
                we_d   = 1'b0;
                busy_d = 1'b0;
                if (start_i) begin
                    xmin_d  = (w_x0c < w_x1c) ? w_x0c : w_x1c;
                    xmax_d  = (w_x0c < w_x1c) ? w_x1c : w_x0c;
                    ymax_d  = (w_y0c < w_y1c) ? w_y1c : w_y0c;
                    x_d     = xmin_d;
                    y_d     = (w_y0c < w_y1c) ? w_y0c : w_y1c;
                    color_d = color_i;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Abort takes priority, even over acceptance of the last pixel.
                if (abort_i) begin
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (w_accept) begin
                    if (x_q == xmax_q) begin
                        if (y_q == ymax_q) begin
                            we_d    = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            x_d = xmin_q;
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            color_q <= color_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wr_we_o     = we_q;
    assign wr_addr_x_o = x_q;
    assign wr_addr_y_o = y_q;
    assign wr_color_o  = color_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rect_fill_ctrl
// Purpose  : Directed plus random fills checked against a raster-order model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_rect_fill_ctrl;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

`ifdef VGA_RECT_FILL_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [10:0] x0_i = '0, y0_i = '0, x1_i = '0, y1_i = '0;
    logic [0:0]  color_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, wr_we_o;
    logic [10:0] wr_addr_x_o, wr_addr_y_o;
    logic [0:0]  wr_color_o;
    logic        wr_ready_i = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    vga_rect_fill_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .x0_i        (x0_i),
        .y0_i        (y0_i),
        .x1_i        (x1_i),
        .y1_i        (y1_i),
        .color_i     (color_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .wr_addr_x_o (wr_addr_x_o),
        .wr_addr_y_o (wr_addr_y_o),
        .wr_color_o  (wr_color_o),
        .wr_we_o     (wr_we_o),
        .wr_ready_i  (wr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int clampv(input int v, input int lim);
        if (CLIP && v > lim - 1) return lim - 1;
        return v;
    endfunction

    // rmode: 0 ready always, 1 pattern 1,0,0, 2 random.
    // stop_kind: 0 none, 1 abort, 2 reset, asserted together with acceptance number stop_at.
    task automatic do_fill(input int x0, input int y0, input int x1, input int y1,
                           input bit col, input int rmode, input int stop_kind,
                           input int stop_at, input bit glitch);
        int qx[$];
        int qy[$];
        int ax, bx, ay, by, xmin, xmax, ymin, ymax;
        int idx, cyc, budget, total;
        bit stopped, rdy;

        ax = clampv(x0, H_RES); bx = clampv(x1, H_RES);
        ay = clampv(y0, V_RES); by = clampv(y1, V_RES);
        xmin = (ax < bx) ? ax : bx; xmax = (ax < bx) ? bx : ax;
        ymin = (ay < by) ? ay : by; ymax = (ay < by) ? by : ay;
        for (int y = ymin; y <= ymax; y++)
            for (int x = xmin; x <= xmax; x++) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        total  = qx.size();
        budget = total * 6 + 20;

        check("idle_before_start", busy_o, 0);
        start_i = 1'b1;
        x0_i = 11'(x0); y0_i = 11'(y0); x1_i = 11'(x1); y1_i = 11'(y1);
        color_i = col;
        wr_ready_i = 1'b1;
        step();
        start_i = 1'b0;

        idx = 0; cyc = 0; stopped = 1'b0;
        while (idx < total && !stopped && cyc < budget) begin
            check("fill_we", wr_we_o, 1);
            check("fill_busy", busy_o, 1);
            check("fill_done", done_o, 0);
            check("addr_x", wr_addr_x_o, qx[idx]);
            check("addr_y", wr_addr_y_o, qy[idx]);
            check("color", wr_color_o, col);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3) == 0;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            wr_ready_i = rdy;
            if (glitch) begin
                start_i = 1'b1;
                x0_i = 11'($urandom_range(0, 30)); y0_i = 11'($urandom_range(0, 30));
                x1_i = 11'($urandom_range(0, 30)); y1_i = 11'($urandom_range(0, 30));
            end
            if (rdy && stop_kind != 0 && idx + 1 == stop_at) begin
                if (stop_kind == 1) abort_i = 1'b1;
                else rst_i = 1'b1;
                stopped = 1'b1;
            end
            if (rdy) idx++;
            step();
            cyc++;
            abort_i = 1'b0;
            rst_i   = 1'b0;
        end

        wr_ready_i = 1'b1;
        if (stopped) begin
            check("stop_we", wr_we_o, 0);
            check("stop_busy", busy_o, 0);
            check("stop_done", done_o, 0);
            if (stop_kind == 2) begin
                check("rst_addr_x", wr_addr_x_o, 0);
                check("rst_addr_y", wr_addr_y_o, 0);
                check("rst_color", wr_color_o, 0);
            end
            step();
            check("stop_we_after", wr_we_o, 0);
            check("stop_busy_after", busy_o, 0);
        end else begin
            check("accepted", idx, total);
            check("done_pulse", done_o, 1);
            check("done_we", wr_we_o, 0);
            check("done_busy", busy_o, 1);
            if (glitch) abort_i = 1'b1;
            step();
            start_i = 1'b0;
            abort_i = 1'b0;
            check("post_done", done_o, 0);
            check("post_busy", busy_o, 0);
            check("post_we", wr_we_o, 0);
            if (glitch) begin
                step();
                check("no_queued_start_we", wr_we_o, 0);
                check("no_queued_start_busy", busy_o, 0);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        step();
        step();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_we", wr_we_o, 0);
        check("rst_addr_x", wr_addr_x_o, 0);
        check("rst_addr_y", wr_addr_y_o, 0);
        check("rst_color", wr_color_o, 0);
        rst_i = 1'b0;
        step();
        check("idle_busy", busy_o, 0);

        // Basic 3x2, swapped corners, stalled handshake.
        do_fill(2, 3, 4, 4, 1'b1, 0, 0, 0, 1'b0);
        do_fill(4, 4, 2, 3, 1'b1, 0, 0, 0, 1'b0);
        do_fill(2, 3, 4, 4, 1'b1, 1, 0, 0, 1'b0);
        // 1x1 with start/abort pulses outside IDLE.
        do_fill(5, 7, 5, 7, 1'b1, 0, 0, 0, 1'b1);
        // 4x4 aborted on 3rd acceptance, then a fresh fill.
        do_fill(0, 0, 3, 3, 1'b1, 0, 1, 3, 1'b0);
        do_fill(2, 3, 4, 4, 1'b0, 0, 0, 0, 1'b0);
        // Same with reset in place of abort.
        do_fill(0, 0, 3, 3, 1'b1, 0, 2, 3, 1'b0);
        do_fill(1, 1, 3, 2, 1'b1, 2, 0, 0, 1'b0);
        // Abort coinciding with last-pixel acceptance: no done pulse.
        do_fill(6, 6, 7, 6, 1'b1, 0, 1, 2, 1'b0);
        // Edge-of-screen rectangle.
        do_fill(638, 478, 700, 500, 1'b1, 0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_fill($urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9),
                    1'($urandom_range(0, 1)), 2, 0, 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
